// File: rtl/decoder_line_encoder.sv
// Registered 4-to-2 line encoder: re-encodes a decoded line vector F[0:3] into {A,B}
// behind a valid/ready 2-entry FIFO, flagging and counting non-one-hot vectors.
module decoder_line_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           F_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 A_out,
    output logic                 B_out,
    output logic                 err_out,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clr_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    typedef struct packed {
        logic a;
        logic b;
        logic err;
    } entry_t;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    fifo_state_e          state_q, state_d;
    entry_t               head_q, head_d;
    entry_t               tail_q, tail_d;
    logic                 in_ready_q;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic   [1:0] line_idx;
    logic         one_hot;
    entry_t       enc;
    logic         push;
    logic         pop;

    // Lowest set line wins; an all-zero vector falls through to line 3.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        line_idx = 2'd3;
        casez (F_in)
            4'b???1: line_idx = 2'd0;
            4'b??10: line_idx = 2'd1;
            4'b?100: line_idx = 2'd2;
            default: line_idx = 2'd3;
        endcase
    end

    assign one_hot = (F_in != 4'd0) && ((F_in & (F_in - 4'd1)) == 4'd0);
    assign enc     = '{a: ~line_idx[0], b: ~line_idx[1], err: ~one_hot};

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    // head_q drives the outputs directly, so it only changes when a new entry becomes head.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = enc;
                    state_d = ONE;
                end
            end
            ONE: begin
                unique case ({push, pop})
                    2'b11: head_d = enc;
                    2'b10: begin
                        tail_d  = enc;
                        state_d = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    default: ;
                endcase
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Clear wins over the pending value, then an errored push on the same edge still counts.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = (push && enc.err) ? ERR_CNT_W'(1) : '0;
        end else if (push && enc.err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two storage entries are reset too, because the head entry is visible on the outputs.
            state_q    <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
            err_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= (state_d != FULL);
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign A_out     = head_q.a;
    assign B_out     = head_q.b;
    assign err_out   = head_q.err;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_decoder_line_encoder.sv
// Randomized and directed bench for decoder_line_encoder against a queue-based model;
// a second instance with a 2-bit counter exercises saturation alongside the default width.
module tb_decoder_line_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] F_in;
    logic       out_ready;
    logic       clr_err;

    logic       in_ready, out_valid, A_out, B_out, err_out;
    logic [7:0] err_count;
    logic       in_ready2, out_valid2, A_out2, B_out2, err_out2;
    logic [1:0] err_count2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit a;
        bit b;
        bit err;
    } ent_t;

    ent_t mq[$];
    ent_t exp_head;
    int   exp_cnt8;
    int   exp_cnt2;

    decoder_line_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F_in      (F_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A_out     (A_out),
        .B_out     (B_out),
        .err_out   (err_out),
        .err_count (err_count),
        .clr_err   (clr_err)
    );

    decoder_line_encoder #(.ERR_CNT_W(2)) dut_w2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .F_in      (F_in),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .A_out     (A_out2),
        .B_out     (B_out2),
        .err_out   (err_out2),
        .err_count (err_count2),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference encoding: find the lowest set line, count set lines.
    function automatic ent_t model_enc(input logic [3:0] f);
        ent_t e;
        int   idx = 3;
        for (int i = 3; i >= 0; i--) if (f[i]) idx = i;
        e.a   = (idx % 2) == 0;
        e.b   = (idx / 2) == 0;
        e.err = $countones(f) != 1;
        return e;
    endfunction

    function automatic int next_cnt(input int cnt, input int maxv, input bit clr, input bit inc);
        if (clr) return inc ? 1 : 0;
        if (inc) return (cnt < maxv) ? cnt + 1 : cnt;
        return cnt;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_head = '{a: 1'b0, b: 1'b0, err: 1'b0};
        exp_cnt8 = 0;
        exp_cnt2 = 0;
    endtask

    task automatic check_all();
        check("in_ready",   in_ready,   mq.size() < 2);
        check("out_valid",  out_valid,  mq.size() > 0);
        check("A_out",      A_out,      exp_head.a);
        check("B_out",      B_out,      exp_head.b);
        check("err_out",    err_out,    exp_head.err);
        check("err_count",  err_count,  exp_cnt8);
        check("err_count2", err_count2, exp_cnt2);
    endtask

    // Called just after a falling edge: drive, let one rising edge pass, update model, check.
    task automatic do_cycle(input bit iv, input logic [3:0] f, input bit ordy, input bit clr);
        ent_t e;
        bit   push;
        bit   pop;
        in_valid  = iv;
        F_in      = f;
        out_ready = ordy;
        clr_err   = clr;
        e    = model_enc(f);
        push = iv && (mq.size() < 2);
        pop  = ordy && (mq.size() > 0);
        @(posedge clk);
        if (pop) mq.delete(0);
        if (push) mq.push_back(e);
        if (mq.size() > 0) exp_head = mq[0];
        exp_cnt8 = next_cnt(exp_cnt8, 255, clr, push && e.err);
        exp_cnt2 = next_cnt(exp_cnt2, 3,   clr, push && e.err);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [3:0] lines [4];
        lines[0] = 4'b0001;
        lines[1] = 4'b0010;
        lines[2] = 4'b0100;
        lines[3] = 4'b1000;

        // Reset with a pending vector: nothing may be accepted.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        F_in      = 4'b0001;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        do_cycle(1'b1, 4'b0001, 1'b1, 1'b0);
        do_cycle(1'b0, 4'b0000, 1'b1, 1'b0);

        // One-hot vectors back to back with a ready consumer.
        for (int i = 0; i < 4; i++) do_cycle(1'b1, lines[i], 1'b1, 1'b0);
        do_cycle(1'b0, 4'b0000, 1'b1, 1'b0);

        // Zero-hot and multi-hot.
        do_cycle(1'b1, 4'b0000, 1'b1, 1'b0);
        do_cycle(1'b1, 4'b0110, 1'b1, 1'b0);
        do_cycle(1'b0, 4'b0000, 1'b1, 1'b0);

        // Stalled consumer: fill, offer a third, then drain.
        do_cycle(1'b1, 4'b0010, 1'b0, 1'b0);
        do_cycle(1'b1, 4'b0100, 1'b0, 1'b0);
        do_cycle(1'b1, 4'b1000, 1'b0, 1'b0);
        do_cycle(1'b1, 4'b1000, 1'b0, 1'b0);
        do_cycle(1'b1, 4'b1000, 1'b1, 1'b0);
        do_cycle(1'b0, 4'b0000, 1'b1, 1'b0);
        do_cycle(1'b0, 4'b0000, 1'b1, 1'b0);
        do_cycle(1'b0, 4'b0000, 1'b1, 1'b0);

        // Steady push/pop in the one-entry state.
        do_cycle(1'b1, 4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) do_cycle(1'b1, lines[i % 4], 1'b1, 1'b0);
        do_cycle(1'b0, 4'b0000, 1'b1, 1'b0);

        // Saturate the 2-bit counter, then clear with an errored push.
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 4'b0011, 1'b1, 1'b0);
        do_cycle(1'b1, 4'b0000, 1'b1, 1'b1);
        do_cycle(1'b1, 4'b0100, 1'b0, 1'b0);

        // Asynchronous reset mid-stream, away from any clock edge.
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        do_cycle(1'b1, 4'b1000, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom_range(0, 3) != 0), 4'($urandom),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
        end

        // Saturate the default-width counter, then clear with an errored push.
        do_cycle(1'b0, 4'b0000, 1'b1, 1'b1);
        for (int i = 0; i < 270; i++) do_cycle(1'b1, 4'b0000, 1'b1, 1'b0);
        do_cycle(1'b1, 4'b1111, 1'b1, 1'b1);
        do_cycle(1'b1, 4'b0001, 1'b1, 1'b1);
        do_cycle(1'b0, 4'b0000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
